// File: rtl/decode_stage.sv
// Registered RV32I/RV32E (+optional M) decode stage with valid/ready handshake on both sides.
// A one-entry skid buffer lets o_ready come straight from a flop.
module decode_stage #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter bit          ENABLE_M   = 1'b0,
    parameter int unsigned ALU_OP_W   = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [INST_WIDTH-1:0]       i_inst,
    input  logic [INST_WIDTH-1:0]       i_pc,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [INST_WIDTH-1:0]       o_pc,
    output logic [6:0]                  o_opcode,
    output logic [2:0]                  o_funct3,
    output logic                        o_branch,
    output logic [2:0]                  o_branch_op,
    output logic [1:0]                  o_result_mux,
    output logic                        o_mem_write,
    output logic                        o_alu_src_a,
    output logic                        o_alu_src_b,
    output logic                        o_reg_write,
    output logic [ALU_OP_W-1:0]         o_alu_op,
    output logic [$clog2(NUM_REGS)-1:0] o_rs1_addr,
    output logic [$clog2(NUM_REGS)-1:0] o_rs2_addr,
    output logic [$clog2(NUM_REGS)-1:0] o_rd_addr,
    output logic                        o_illegal
);
    localparam int unsigned RegW = $clog2(NUM_REGS);

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [ALU_OP_W-1:0] AluNop  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] AluAdd  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] AluSub  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] AluSll  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] AluSlt  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] AluSltu = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] AluXor  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] AluSrl  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] AluSra  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] AluOr   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] AluAnd  = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] AluMul  = ALU_OP_W'(16);

    // Conditional branches reuse funct3; JAL/JALR take the two funct3 slots branches never use.
    localparam logic [2:0] BrJal  = 3'd2;
    localparam logic [2:0] BrJalr = 3'd3;

    typedef struct packed {
        logic [INST_WIDTH-1:0] pc;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic                  branch;
        logic [2:0]            branch_op;
        logic [1:0]            result_mux;
        logic                  mem_write;
        logic                  alu_src_a;
        logic                  alu_src_b;
        logic                  reg_write;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [RegW-1:0]       rs1;
        logic [RegW-1:0]       rs2;
        logic [RegW-1:0]       rd;
        logic                  illegal;
    } bundle_t;

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    function automatic logic [ALU_OP_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return alt ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    bundle_t    dec;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1_f, rs2_f, rd_f;
    logic       use_rs1, use_rs2, use_rd, bad;

    always_comb begin
        opcode  = i_inst[6:0];
        funct3  = i_inst[14:12];
        funct7  = i_inst[31:25];
        rs1_f   = i_inst[19:15];
        rs2_f   = i_inst[24:20];
        rd_f    = i_inst[11:7];
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        bad     = 1'b0;
        dec        = '0;
        dec.pc     = i_pc;
        dec.opcode = opcode;
        dec.funct3 = funct3;
        case (opcode)
            OpcLui: begin
                dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; dec.alu_op = AluAdd;
                use_rd = 1'b1;
                rs1_f  = '0;
            end
            OpcAuipc: begin
                dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = AluAdd; use_rd = 1'b1;
            end
            OpcJal: begin
                dec.branch = 1'b1; dec.branch_op = BrJal; dec.result_mux = 2'b01;
                dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = AluAdd; use_rd = 1'b1;
            end
            OpcJalr: begin
                dec.branch = 1'b1; dec.branch_op = BrJalr; dec.result_mux = 2'b01;
                dec.alu_src_b = 1'b1; dec.reg_write = 1'b1; dec.alu_op = AluAdd;
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OpcBranch: begin
                dec.branch = 1'b1; dec.branch_op = funct3;
                dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.alu_op = AluAdd;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcLoad: begin
                dec.result_mux = 2'b10; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = AluAdd; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OpcStore: begin
                dec.mem_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_op = AluAdd;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OpcOpImm: begin
                dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = alu_base(funct3, (funct3 == 3'b101) && (funct7 == 7'b0100000));
                use_rs1 = 1'b1; use_rd = 1'b1;
                if ((funct3 == 3'b001) && (funct7 != 7'b0000000)) bad = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000)) begin
                    bad = 1'b1;
                end
            end
            OpcOp: begin
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec.alu_op = alu_base(funct3, 1'b0);
                end else if ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    dec.alu_op = alu_base(funct3, 1'b1);
                end else if (ENABLE_M && (funct7 == 7'b0000001)) begin
                    dec.alu_op = AluMul + ALU_OP_W'(funct3);
                end else begin
                    bad = 1'b1;
                end
            end
            OpcFence, OpcSystem: ;
            default: bad = 1'b1;
        endcase
        // RV32E only has x0..x15: any referenced index with bit 4 set is unencodable.
        if (NUM_REGS == 16) begin
            bad = bad | (use_rs1 & rs1_f[4]) | (use_rs2 & rs2_f[4]) | (use_rd & rd_f[4]);
        end
        if (bad) begin
            dec.branch     = 1'b0;
            dec.branch_op  = '0;
            dec.result_mux = '0;
            dec.mem_write  = 1'b0;
            dec.alu_src_a  = 1'b0;
            dec.alu_src_b  = 1'b0;
            dec.reg_write  = 1'b0;
            dec.alu_op     = AluNop;
            dec.illegal    = 1'b1;
        end
        dec.rs1 = rs1_f[RegW-1:0];
        dec.rs2 = rs2_f[RegW-1:0];
        dec.rd  = rd_f[RegW-1:0];
    end

    state_e  state_q, state_d;
    bundle_t out_q, out_d, skid_q, skid_d;
    logic    valid_q, valid_d, ready_q, ready_d;
    logic    accept, drain;

    always_comb begin
        accept  = i_valid & ready_q;
        drain   = valid_q & i_ready;
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (accept && drain) begin
                        out_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = StSkid;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = StFull;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        valid_d = (state_d != StEmpty);
        ready_d = (state_d != StSkid);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_pc         = out_q.pc;
    assign o_opcode     = out_q.opcode;
    assign o_funct3     = out_q.funct3;
    assign o_branch     = out_q.branch;
    assign o_branch_op  = out_q.branch_op;
    assign o_result_mux = out_q.result_mux;
    assign o_mem_write  = out_q.mem_write;
    assign o_alu_src_a  = out_q.alu_src_a;
    assign o_alu_src_b  = out_q.alu_src_b;
    assign o_reg_write  = out_q.reg_write;
    assign o_alu_op     = out_q.alu_op;
    assign o_rs1_addr   = out_q.rs1;
    assign o_rs2_addr   = out_q.rs2;
    assign o_rd_addr    = out_q.rd;
    assign o_illegal    = out_q.illegal;

endmodule
